aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Round sequencer for the AES cipher core. It accepts one block-cipher request per handshake and latches the direction and key length. It then steps the state and full-key registers through the initial AddRoundKey, the middle rounds and the final round, driving the mux selects and write enables of the round datapath (ShiftRows, SubBytes, MixColumns, AddRoundKey, key expand). It presents the result with a valid/ready handshake. It sits between the AES main control FSM and the cipher datapath.

## Interface
- No parameters; encodings are the package values: `CIPH_FWD`=0/`CIPH_INV`=1; `AES_128`=001, `AES_192`=010, `AES_256`=100; `STATE_INIT/ROUND/CLEAR`=0/1/2; `ADD_RK_INIT/ROUND/FINAL`=0/1/2; `KEY_FULL_ENC_INIT/DEC_INIT/ROUND/CLEAR`=0/1/2/3.
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  request valid
- in_ready_o  out  1  ready to accept request
- op_i  in  1  direction, sampled on accept
- key_len_i  in  3  one-hot key length, sampled on accept
- out_valid_o  out  1  result in state register valid
- out_ready_i  in  1  consumer accepts result
- op_o  out  1  latched direction, drives ShiftRows/MixColumns/SubBytes direction
- round_o  out  4  current round index
- state_we_o  out  1  state register write enable
- state_sel_o  out  2  state register input select
- add_rk_sel_o  out  2  AddRoundKey input select
- key_full_we_o  out  1  full-key register write enable
- key_full_sel_o  out  2  full-key register input select
- key_expand_en_o  out  1  advance key expansion one round
- key_len_err_o  out  1  one-cycle pulse: non-one-hot key_len_i on accept
- busy_o  out  1  high in every state except IDLE

## Operation
- States: IDLE, ROUND, FINAL, DONE, plus CLEAR (see Configuration).
- **IDLE**
  - in_ready_o=1; all enables 0; selects 0.
  - On accept (in_valid_i & in_ready_o), same cycle:
    - state_we_o=1, state_sel_o=STATE_INIT, add_rk_sel_o=ADD_RK_INIT.
    - key_full_we_o=1, key_full_sel_o = KEY_FULL_ENC_INIT if op_i=CIPH_FWD, else KEY_FULL_DEC_INIT.
    - Latch op_i and N: 10/12/14 for 001/010/100; any other key_len_i gives N=10 and key_len_err_o=1.
    - round_o←1. Next state: ROUND, or FINAL if N=1 (unreachable; guarded).
- **ROUND** (round_o = 1..N-1)
  - Each cycle: state_we_o=1, state_sel_o=STATE_ROUND, add_rk_sel_o=ADD_RK_ROUND.
  - key_full_we_o=1, key_full_sel_o=KEY_FULL_ROUND, key_expand_en_o=1.
  - round_o increments; when round_o=N-1, next state is FINAL.
- **FINAL** (round_o=N): same as ROUND except add_rk_sel_o=ADD_RK_FINAL; next state DONE.
- **DONE**: out_valid_o=1, all enables 0, round_o held at N. On out_ready_i, go to IDLE (or CLEAR); round_o←0.
- op_i and key_len_i changes outside the accept cycle are ignored.
- in_ready_o and out_valid_o are never high in the same cycle, so a new accept cannot coincide with output completion.

## Timing
- Reset values: in_ready_o=1; all other outputs 0 (round_o=0, op_o=0); state IDLE.
- Accept in cycle 0. ROUND occupies cycles 1..N-1 and FINAL cycle N. out_valid_o is first high in cycle N+1:
  - AES-128: 11 cycles
  - AES-192: 13 cycles
  - AES-256: 15 cycles
- out_valid_o stays high and outputs stay stable until out_ready_i; a DONE stall has unbounded length.
- in_ready_o re-asserts the cycle after the output handshake, or one cycle later with CLEAR.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). No output is produced for the aborted request.
- Throughput without CLEAR: N+2 cycles per block with out_ready_i held high.

## Configuration
- `AES_ROUND_CTRL_CLEAR_EN` defined:
  - After the output handshake, the FSM spends exactly one cycle in CLEAR: state_we_o=1, state_sel_o=STATE_CLEAR, key_full_we_o=1, key_full_sel_o=KEY_FULL_CLEAR, in_ready_o=0, busy_o=1.
  - Then IDLE. Throughput becomes N+3.
- Undefined: the CLEAR state and its logic are absent; DONE goes directly to IDLE.

## Test plan
- Reset, then AES-128 encrypt:
  - in_valid_i=1, op_i=0, key_len_i=001 in cycle 0.
  - Required: round_o 1..10 in cycles 1..10; add_rk_sel_o=2 only in cycle 10; out_valid_o high from cycle 11.
  - key_full_sel_o=0 and state_sel_o=0 in cycle 0.
- AES-256 decrypt:
  - key_len_i=100, op_i=1.
  - Required: 14 round cycles; op_o=1 throughout; key_full_sel_o=1 on accept; out_valid_o in cycle 15.
- Invalid key length:
  - key_len_i=011.
  - Required: key_len_err_o pulses in cycle 0 only; 10 rounds executed.
- Backpressure:
  - out_ready_i=0 for 5 cycles after DONE.
  - Required: out_valid_o held; all enables 0; in_valid_i=1 is not accepted (in_ready_o=0).
- Async reset in round 6 of AES-192:
  - Required: busy_o=0, in_ready_o=1, round_o=0 immediately; no out_valid_o.
  - The next request completes normally in 13 cycles.
- With `AES_ROUND_CTRL_CLEAR_EN`:
  - Required: one cycle of state_sel_o=2, key_full_sel_o=3 with both enables high after the handshake; in_ready_o rises one cycle later than without the macro.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: steps the state and full-key registers through init, middle and final rounds.
// Optional build macro AES_ROUND_CTRL_CLEAR_EN adds a one-cycle register-clear state after each output.
module aes_round_ctrl (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       op_i,
  input  logic [2:0] key_len_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       op_o,
  output logic [3:0] round_o,
  output logic       state_we_o,
  output logic [1:0] state_sel_o,
  output logic [1:0] add_rk_sel_o,
  output logic       key_full_we_o,
  output logic [1:0] key_full_sel_o,
  output logic       key_expand_en_o,
  output logic       key_len_err_o,
  output logic       busy_o
);

  localparam logic       CIPH_FWD = 1'b0;

  localparam logic [2:0] AES_128 = 3'b001;
  localparam logic [2:0] AES_192 = 3'b010;
  localparam logic [2:0] AES_256 = 3'b100;

  localparam logic [1:0] STATE_INIT  = 2'd0;
  localparam logic [1:0] STATE_ROUND = 2'd1;

  localparam logic [1:0] ADD_RK_INIT  = 2'd0;
  localparam logic [1:0] ADD_RK_ROUND = 2'd1;
  localparam logic [1:0] ADD_RK_FINAL = 2'd2;

  localparam logic [1:0] KEY_FULL_ENC_INIT = 2'd0;
  localparam logic [1:0] KEY_FULL_DEC_INIT = 2'd1;
  localparam logic [1:0] KEY_FULL_ROUND    = 2'd2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ROUND = 3'd1;
  localparam logic [2:0] S_FINAL = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef AES_ROUND_CTRL_CLEAR_EN
  localparam logic [2:0] S_CLEAR = 3'd4;

  localparam logic [1:0] STATE_CLEAR    = 2'd2;
  localparam logic [1:0] KEY_FULL_CLEAR = 2'd3;
`endif

  // Unknown key lengths fall back to the AES-128 schedule and are flagged separately.
  function automatic logic [3:0] num_rounds(input logic [2:0] kl);
    case (kl)
      AES_128: num_rounds = 4'd10;
      AES_192: num_rounds = 4'd12;
      AES_256: num_rounds = 4'd14;
      default: num_rounds = 4'd10;
    endcase
  endfunction

  function automatic logic key_len_ok(input logic [2:0] kl);
    key_len_ok = (kl == AES_128) || (kl == AES_192) || (kl == AES_256);
  endfunction

  logic [2:0] state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] nrounds_q, nrounds_d;
  logic       op_q, op_d;
  logic [3:0] nrounds_in;

  assign nrounds_in = num_rounds(key_len_i);

  always_comb begin
    state_d         = state_q;
    round_d         = round_q;
    nrounds_d       = nrounds_q;
    op_d            = op_q;
    in_ready_o      = 1'b0;
    out_valid_o     = 1'b0;
    state_we_o      = 1'b0;
    state_sel_o     = STATE_INIT;
    add_rk_sel_o    = ADD_RK_INIT;
    key_full_we_o   = 1'b0;
    key_full_sel_o  = KEY_FULL_ENC_INIT;
    key_expand_en_o = 1'b0;
    key_len_err_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          state_we_o     = 1'b1;
          state_sel_o    = STATE_INIT;
          add_rk_sel_o   = ADD_RK_INIT;
          key_full_we_o  = 1'b1;
          key_full_sel_o = (op_i == CIPH_FWD) ? KEY_FULL_ENC_INIT : KEY_FULL_DEC_INIT;
          key_len_err_o  = ~key_len_ok(key_len_i);
          op_d           = op_i;
          nrounds_d      = nrounds_in;
          round_d        = 4'd1;
          state_d        = (nrounds_in == 4'd1) ? S_FINAL : S_ROUND;
        end
      end

      S_ROUND: begin
        state_we_o      = 1'b1;
        state_sel_o     = STATE_ROUND;
        add_rk_sel_o    = ADD_RK_ROUND;
        key_full_we_o   = 1'b1;
        key_full_sel_o  = KEY_FULL_ROUND;
        key_expand_en_o = 1'b1;
        round_d         = round_q + 4'd1;
        if (round_q == nrounds_q - 4'd1) begin
          state_d = S_FINAL;
        end
      end

      S_FINAL: begin
        state_we_o      = 1'b1;
        state_sel_o     = STATE_ROUND;
        add_rk_sel_o    = ADD_RK_FINAL;
        key_full_we_o   = 1'b1;
        key_full_sel_o  = KEY_FULL_ROUND;
        key_expand_en_o = 1'b1;
        state_d         = S_DONE;
      end

      S_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          round_d = 4'd0;
`ifdef AES_ROUND_CTRL_CLEAR_EN
          state_d = S_CLEAR;
`else
          state_d = S_IDLE;
`endif
        end
      end

`ifdef AES_ROUND_CTRL_CLEAR_EN
      // Wipe state and key material before the next request can be accepted.
      S_CLEAR: begin
        state_we_o     = 1'b1;
        state_sel_o    = STATE_CLEAR;
        key_full_we_o  = 1'b1;
        key_full_sel_o = KEY_FULL_CLEAR;
        state_d        = S_IDLE;
      end
`endif

      default: begin
        state_d = S_IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      round_q   <= 4'd0;
      nrounds_q <= 4'd10;
      op_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      nrounds_q <= nrounds_d;
      op_q      <= op_d;
    end
  end

  assign op_o    = op_q;
  assign round_o = round_q;
  assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: encrypt/decrypt sequences, bad key length, backpressure, async abort.
// Honors AES_ROUND_CTRL_CLEAR_EN to expect the extra clear cycle.
module tb_aes_round_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       op_in;
  logic [2:0] key_len;
  logic       out_valid;
  logic       out_ready;
  logic       op_out;
  logic [3:0] round;
  logic       state_we;
  logic [1:0] state_sel;
  logic [1:0] add_rk_sel;
  logic       kf_we;
  logic [1:0] kf_sel;
  logic       kexp_en;
  logic       kl_err;
  logic       busy;

  int errs   = 0;
  int checks = 0;

  aes_round_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .op_i           (op_in),
    .key_len_i      (key_len),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .op_o           (op_out),
    .round_o        (round),
    .state_we_o     (state_we),
    .state_sel_o    (state_sel),
    .add_rk_sel_o   (add_rk_sel),
    .key_full_we_o  (kf_we),
    .key_full_sel_o (kf_sel),
    .key_expand_en_o(kexp_en),
    .key_len_err_o  (kl_err),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input logic op, input logic [2:0] kl, input int n,
                         input logic exp_err, input int stall);
    next_cycle();
    in_valid  = 1'b1;
    op_in     = op;
    key_len   = kl;
    out_ready = 1'b0;
    @(negedge clk);
    chk("acc_in_ready", in_ready, 1);
    chk("acc_state_we", state_we, 1);
    chk("acc_state_sel", state_sel, 0);
    chk("acc_add_rk_sel", add_rk_sel, 0);
    chk("acc_kf_we", kf_we, 1);
    chk("acc_kf_sel", kf_sel, op ? 1 : 0);
    chk("acc_kexp_en", kexp_en, 0);
    chk("acc_kl_err", kl_err, exp_err);
    chk("acc_round", round, 0);
    chk("acc_busy", busy, 0);

    for (int r = 1; r <= n; r++) begin
      next_cycle();
      in_valid = 1'b0;
      op_in    = ~op;
      key_len  = 3'b111;
      @(negedge clk);
      chk("rnd_round", round, r);
      chk("rnd_add_rk_sel", add_rk_sel, (r == n) ? 2 : 1);
      chk("rnd_state_we", state_we, 1);
      chk("rnd_state_sel", state_sel, 1);
      chk("rnd_kf_we", kf_we, 1);
      chk("rnd_kf_sel", kf_sel, 2);
      chk("rnd_kexp_en", kexp_en, 1);
      chk("rnd_kl_err", kl_err, 0);
      chk("rnd_op_o", op_out, op);
      chk("rnd_busy", busy, 1);
      chk("rnd_in_ready", in_ready, 0);
      chk("rnd_out_valid", out_valid, 0);
    end

    for (int s = 0; s < stall; s++) begin
      next_cycle();
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_state_we", state_we, 0);
      chk("stall_kf_we", kf_we, 0);
      chk("stall_kexp_en", kexp_en, 0);
      chk("stall_round", round, n);
      chk("stall_op_o", op_out, op);
      chk("stall_busy", busy, 1);
    end

    next_cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("done_out_valid", out_valid, 1);
    chk("done_in_ready", in_ready, 0);
    chk("done_round", round, n);
    chk("done_state_we", state_we, 0);

`ifdef AES_ROUND_CTRL_CLEAR_EN
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_in_ready", in_ready, 0);
    chk("clr_busy", busy, 1);
    chk("clr_state_we", state_we, 1);
    chk("clr_state_sel", state_sel, 2);
    chk("clr_kf_we", kf_we, 1);
    chk("clr_kf_sel", kf_sel, 3);
    chk("clr_round", round, 0);
`endif

    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_round", round, 0);
    chk("idle_state_we", state_we, 0);
  endtask

  initial begin
    int seen_valid;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    op_in     = 1'b0;
    key_len   = 3'b001;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_round", round, 0);
    chk("rst_op_o", op_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_state_we", state_we, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_req(1'b0, 3'b001, 10, 1'b0, 0);
    run_req(1'b1, 3'b100, 14, 1'b0, 0);
    run_req(1'b0, 3'b011, 10, 1'b1, 5);
    run_req(1'b1, 3'b000, 10, 1'b1, 0);
    run_req(1'b0, 3'b010, 12, 1'b0, 2);

    // Abort an AES-192 request during round 6.
    next_cycle();
    in_valid = 1'b1;
    op_in    = 1'b1;
    key_len  = 3'b010;
    for (int r = 1; r <= 6; r++) begin
      next_cycle();
      in_valid = 1'b0;
    end
    @(negedge clk);
    chk("abort_pre_round", round, 6);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_round", round, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_op_o", op_out, 0);
    chk("abort_state_we", state_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    chk("abort_no_output", seen_valid, 0);

    run_req(1'b0, 3'b010, 12, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
